regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port between two writeback requesters: A (ALU) and B (load unit).
//  Each requester has a valid/ready handshake into its own FIFO.
//  A round-robin arbiter drains the FIFOs and drives a registered write to the register file, at most one write per cycle.
//  Two hazard outputs flag any register that still has a write pending.
//  Sits between the execute/memory stages and the register file write inputs (write_en, write_data, reg_en).
// PARAMETERS
//  bits             32  data width of each register
//  no_of_registers  32  register count; AW = $clog2(no_of_registers)
//  FIFO_DEPTH       2   entries per requester FIFO; power of 2, >= 2
// PORTS
//  clk          in   1     rising-edge clock
//  async_reset  in   1     asynchronous, active-low reset
//  a_valid      in   1     A write request
//  a_ready      out  1     A FIFO can accept
//  a_addr       in   AW    A destination register
//  a_data       in   bits  A write data
//  b_valid      in   1     B write request
//  b_ready      out  1     B FIFO can accept
//  b_addr       in   AW    B destination register
//  b_data       in   bits  B write data
//  rf_waddr     out  AW    to register file write_en (register index)
//  rf_wdata     out  bits  to register file write_data
//  rf_reg_en    out  1     to register file reg_en; one write per cycle when high
//  chk_reg1     in   AW    register index to check for a pending write
//  chk_reg2     in   AW    register index to check for a pending write
//  hazard1      out  1     chk_reg1 has a write pending
//  hazard2      out  1     chk_reg2 has a write pending
//  idle         out  1     nothing buffered or issuing
// BEHAVIOUR
//  Reset (async_reset=0, async):
//   - FIFOs empty; rf_reg_en=0, rf_waddr=0, rf_wdata=0.
//   - last_grant=B, so A wins the first tie.
//   - a_ready=b_ready=1 (count 0); pushes while in reset are discarded; idle=1.
//   - Mid-operation reset drops all buffered writes; rf_reg_en falls without waiting for clk.
//  Accept: x_ready = (count_x < FIFO_DEPTH), decoded from the registered count.
//   - A push does not pass through a full FIFO, even with a pop in the same cycle.
//   - Push occurs when x_valid & x_ready.
//  Register 0: a push to addr 0 completes the handshake but is not stored; it never reaches rf_*.
//  Arbitration, evaluated every cycle on the FIFO heads:
//   - Only one head non-empty: grant it.
//   - Both non-empty: grant the source != last_grant.
//   - last_grant updates on every grant; the granted head is popped that cycle.
//  Issue: the grant is registered into rf_waddr/rf_wdata with rf_reg_en=1 for exactly one cycle.
//   - With no grant: rf_reg_en=0; rf_waddr/rf_wdata hold their last value.
//  Latency: accept at edge N into an empty FIFO with no contention -> rf_reg_en=1 during the cycle after edge N+1 (2 edges).
//  Throughput: 1 write/cycle total. Under continuous contention each source gets every other cycle.
//  Ordering:
//   - FIFO order is preserved per source.
//   - No ordering between A and B; upstream must use hazard* to avoid same-register WAW across sources.
//  Simultaneous events: a push and a pop on one FIFO in the same cycle both occur; count is unchanged.
//  Hazards (combinational): hazardN = (chk_regN != 0) & (chk_regN matches the addr of any valid FIFO entry, or rf_waddr while rf_reg_en=1).
//  idle = both FIFOs empty & !rf_reg_en.
//  Pointers: FIFO pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits wide.
// TESTING
//  1 Single write: A push addr 5, 0xDEADBEEF at edge 1 -> rf_reg_en=1, rf_waddr=5, rf_wdata=0xDEADBEEF for one cycle after edge 2; then idle=1.
//  2 Tie, first cycle out of reset: A(1,0x11) and B(2,0x22) pushed together -> issues A(1) then B(2) on consecutive cycles.
//    Both held valid for 8 cycles -> rf_waddr alternates A,B,A,B,...; no gap cycles.
//  3 Backpressure (FIFO_DEPTH=2): A always valid; B pushes 4 entries 0xB0..0xB3 back-to-back ->
//    b_ready=0 while the B count is 2; all 4 B entries are written in order, none lost.
//  4 Register 0: A push addr 0, 0xFF -> a_ready stays 1; rf_reg_en never asserts; hazard1=0 with chk_reg1=0.
//  5 Hazard: B push addr 7, chk_reg1=7 -> hazard1=1 from the cycle after accept through the rf_reg_en cycle inclusive, then 0.
//    chk_reg2=8 -> hazard2=0 throughout.
//  6 Mid-operation reset: 3 entries buffered, async_reset=0 mid-cycle -> rf_reg_en=0 immediately.
//    After release: idle=1, a_ready=b_ready=1, no stale write ever issues.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two requester FIFOs (A = ALU, B = load unit) share one
// register-file write port via round-robin, with pending-write hazard lookup.
module regfile_wb_arbiter #(
  parameter int unsigned bits            = 32,
  parameter int unsigned no_of_registers = 32,
  parameter int unsigned FIFO_DEPTH      = 2,
  localparam int unsigned AW             = $clog2(no_of_registers)
) (
  input  logic            clk,
  input  logic            async_reset,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_addr,
  input  logic [bits-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_addr,
  input  logic [bits-1:0] b_data,
  output logic [AW-1:0]   rf_waddr,
  output logic [bits-1:0] rf_wdata,
  output logic            rf_reg_en,
  input  logic [AW-1:0]   chk_reg1,
  input  logic [AW-1:0]   chk_reg2,
  output logic            hazard1,
  output logic            hazard2,
  output logic            idle
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  // Index 0 is source A, index 1 is source B.
  logic [AW-1:0]         addr_q   [2][FIFO_DEPTH];
  logic [bits-1:0]       data_q   [2][FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q    [2];
  logic [PW-1:0]         wr_ptr_q [2];
  logic [PW-1:0]         rd_ptr_q [2];
  logic [CW-1:0]         cnt_q    [2];
  logic                  last_grant_q;  // 0 = A, 1 = B

  logic [1:0]            in_valid;
  logic [AW-1:0]         in_addr [2];
  logic [bits-1:0]       in_data [2];
  logic [1:0]            ready;
  logic [1:0]            not_empty;
  logic [1:0]            push_store;
  logic [1:0]            pop;
  logic                  grant_a;
  logic                  grant_b;

  // Gather the two request ports into source-indexed form and decode acceptance.
  always_comb begin
    in_valid   = {b_valid, a_valid};
    in_addr[0] = a_addr;
    in_addr[1] = b_addr;
    in_data[0] = a_data;
    in_data[1] = b_data;
    for (int s = 0; s < 2; s++) begin
      ready[s]      = (cnt_q[s] < DEPTH_C);
      not_empty[s]  = (cnt_q[s] != '0);
      // Writes to register 0 are acknowledged but dropped.
      push_store[s] = in_valid[s] & ready[s] & (in_addr[s] != '0);
    end
    a_ready = ready[0];
    b_ready = ready[1];
  end

  // Round-robin grant: lone non-empty head wins, otherwise the source not granted last.
  always_comb begin
    grant_a = not_empty[0] & (~not_empty[1] | last_grant_q);
    grant_b = not_empty[1] & ~grant_a;
    pop     = {grant_b, grant_a};
  end

  // FIFO pointers, counts and per-entry valid flags.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      for (int s = 0; s < 2; s++) begin
        vld_q[s]    <= '0;
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push_store[s]) begin
          vld_q[s][wr_ptr_q[s]] <= 1'b1;
          wr_ptr_q[s]           <= wr_ptr_q[s] + PW'(1);
        end
        if (pop[s]) begin
          vld_q[s][rd_ptr_q[s]] <= 1'b0;
          rd_ptr_q[s]           <= rd_ptr_q[s] + PW'(1);
        end
        case ({push_store[s], pop[s]})
          2'b10:   cnt_q[s] <= cnt_q[s] + CW'(1);
          2'b01:   cnt_q[s] <= cnt_q[s] - CW'(1);
          default: cnt_q[s] <= cnt_q[s];
        endcase
      end
    end
  end

  // FIFO storage; contents are qualified by vld_q so no reset is needed.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push_store[s]) begin
        addr_q[s][wr_ptr_q[s]] <= in_addr[s];
        data_q[s][wr_ptr_q[s]] <= in_data[s];
      end
    end
  end

  // Registered write port and round-robin history.
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      rf_reg_en    <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rf_reg_en <= grant_a | grant_b;
      if (grant_a) begin
        rf_waddr     <= addr_q[0][rd_ptr_q[0]];
        rf_wdata     <= data_q[0][rd_ptr_q[0]];
        last_grant_q <= 1'b0;
      end else if (grant_b) begin
        rf_waddr     <= addr_q[1][rd_ptr_q[1]];
        rf_wdata     <= data_q[1][rd_ptr_q[1]];
        last_grant_q <= 1'b1;
      end
    end
  end

  // Pending-write lookup over buffered entries and the write in flight.
  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if (vld_q[s][i]) begin
          if (addr_q[s][i] == chk_reg1) hazard1 = 1'b1;
          if (addr_q[s][i] == chk_reg2) hazard2 = 1'b1;
        end
      end
    end
    if (rf_reg_en && (rf_waddr == chk_reg1)) hazard1 = 1'b1;
    if (rf_reg_en && (rf_waddr == chk_reg2)) hazard2 = 1'b1;
    if (chk_reg1 == '0) hazard1 = 1'b0;
    if (chk_reg2 == '0) hazard2 = 1'b0;
    idle = (cnt_q[0] == '0) && (cnt_q[1] == '0) && !rf_reg_en;
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed pushes, expected writes queued in issue
// order and checked by an independent monitor on the falling edge.
module tb_regfile_wb_arbiter;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          async_reset;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_addr, b_addr;
  logic [31:0]   a_data, b_data;
  logic [AW-1:0] rf_waddr;
  logic [31:0]   rf_wdata;
  logic          rf_reg_en;
  logic [AW-1:0] chk_reg1, chk_reg2;
  logic          hazard1, hazard2;
  logic          idle;

  int total = 0;
  int bad   = 0;
  logic [AW+31:0] exp_q [$];

  regfile_wb_arbiter #(.bits(32), .no_of_registers(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .async_reset(async_reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_reg_en(rf_reg_en),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .hazard1(hazard1), .hazard2(hazard2), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    async_reset = 1'b0;
    #10;
    async_reset = 1'b1;
  endtask

  task automatic push_a(input logic [AW-1:0] ad, input logic [31:0] d);
    logic rdy;
    a_valid = 1'b1; a_addr = ad; a_data = d;
    for (int n = 0; n < 50; n++) begin
      rdy = a_ready;
      tick();
      if (rdy) return;
    end
    chk("push_a_timeout", 32'd1, 32'd0);
  endtask

  task automatic push_b(input logic [AW-1:0] ad, input logic [31:0] d);
    logic rdy;
    b_valid = 1'b1; b_addr = ad; b_data = d;
    for (int n = 0; n < 50; n++) begin
      rdy = b_ready;
      tick();
      if (rdy) return;
    end
    chk("push_b_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  // Monitor: every issued write must match the next expected write.
  always @(negedge clk) begin
    if (async_reset && rf_reg_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h at %0t", rf_waddr, rf_wdata, $time);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        chk("write_addr_data_lo", {rf_waddr, rf_wdata} == e ? 32'd1 : 32'd0, 32'd1);
        if ({rf_waddr, rf_wdata} != e)
          $display("  detail: got addr=%0d data=0x%0h want addr=%0d data=0x%0h",
                   rf_waddr, rf_wdata, e[AW+31:32], e[31:0]);
      end
    end
  end

  int exp_brdy [9] = '{1, 0, 1, 0, 1, 0, 1, 1, 1};

  initial begin
    async_reset = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    chk_reg1 = '0; chk_reg2 = '0;
    tick();

    // Reset state
    chk("rst_reg_en", 32'(rf_reg_en), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    do_reset();

    // 1: single write, two-edge latency
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    tick();
    a_valid = 1'b0;
    chk("t1_no_write_yet", 32'(rf_reg_en), 32'd0);
    chk("t1_not_idle", 32'(idle), 32'd0);
    tick();
    chk("t1_reg_en", 32'(rf_reg_en), 32'd1);
    chk("t1_waddr", 32'(rf_waddr), 32'd5);
    tick();
    chk("t1_reg_en_drop", 32'(rf_reg_en), 32'd0);
    chk("t1_idle", 32'(idle), 32'd1);

    // 2: tie from reset, A wins first, then strict alternation with no gaps
    do_reset();
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back({5'(k + 1), 32'hA000_0000 + 32'(k)});
      exp_q.push_back({5'(k + 10), 32'hB000_0000 + 32'(k)});
    end
    fork
      begin
        for (int k = 0; k < 8; k++) push_a(5'(k + 1), 32'hA000_0000 + 32'(k));
        a_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 8; k++) push_b(5'(k + 10), 32'hB000_0000 + 32'(k));
        b_valid = 1'b0;
      end
      begin
        tick();
        for (int k = 0; k < 16; k++) begin
          tick();
          chk("t2_no_gap", 32'(rf_reg_en), 32'd1);
        end
      end
    join
    drain();

    // 3: backpressure on B while A is continuously busy
    do_reset();
    exp_q.push_back({5'd1, 32'hA0}); exp_q.push_back({5'd20, 32'hB0});
    exp_q.push_back({5'd2, 32'hA1}); exp_q.push_back({5'd21, 32'hB1});
    exp_q.push_back({5'd3, 32'hA2}); exp_q.push_back({5'd22, 32'hB2});
    exp_q.push_back({5'd4, 32'hA3}); exp_q.push_back({5'd23, 32'hB3});
    exp_q.push_back({5'd5, 32'hA4}); exp_q.push_back({5'd6, 32'hA5});
    fork
      begin
        for (int k = 0; k < 6; k++) push_a(5'(k + 1), 32'hA0 + 32'(k));
        a_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 4; k++) push_b(5'(k + 20), 32'hB0 + 32'(k));
        b_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 9; k++) begin
          tick();
          chk("t3_b_ready", 32'(b_ready), 32'(exp_brdy[k]));
        end
      end
    join
    drain();

    // 4: register 0 is acknowledged but never written
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFF; chk_reg1 = 5'd0;
    #1;
    chk("t4_a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    chk("t4_a_ready_after", 32'(a_ready), 32'd1);
    chk("t4_idle", 32'(idle), 32'd1);
    chk("t4_hazard1", 32'(hazard1), 32'd0);
    tick();
    chk("t4_no_write", 32'(rf_reg_en), 32'd0);
    tick();

    // 5: hazard window spans buffering through the write cycle
    chk_reg1 = 5'd7; chk_reg2 = 5'd8;
    exp_q.push_back({5'd7, 32'h0000_7777});
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_7777;
    #1;
    chk("t5_hz1_before", 32'(hazard1), 32'd0);
    tick();
    b_valid = 1'b0;
    chk("t5_hz1_buffered", 32'(hazard1), 32'd1);
    chk("t5_hz2_buffered", 32'(hazard2), 32'd0);
    tick();
    chk("t5_hz1_writing", 32'(hazard1), 32'd1);
    chk("t5_hz2_writing", 32'(hazard2), 32'd0);
    chk("t5_reg_en", 32'(rf_reg_en), 32'd1);
    tick();
    chk("t5_hz1_after", 32'(hazard1), 32'd0);
    drain();

    // 6: mid-operation reset drops everything immediately
    chk_reg1 = 5'd4; chk_reg2 = 5'd9;
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
    tick();
    a_addr = 5'd4; a_data = 32'h44; b_valid = 1'b0;
    tick();
    a_valid = 1'b0;
    chk("t6_issuing_pre_rst", 32'(rf_reg_en), 32'd1);
    chk("t6_hz_buffered", 32'(hazard1 & hazard2), 32'd1);
    async_reset = 1'b0;
    #1;
    chk("t6_reg_en_async", 32'(rf_reg_en), 32'd0);
    chk("t6_hz_cleared", 32'(hazard1 | hazard2), 32'd0);
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC;
    tick();
    tick();
    a_valid = 1'b0;
    #2;
    async_reset = 1'b1;
    #1;
    chk("t6_idle", 32'(idle), 32'd1);
    chk("t6_a_ready", 32'(a_ready), 32'd1);
    chk("t6_b_ready", 32'(b_ready), 32'd1);
    repeat (6) tick();
    chk("t6_idle_later", 32'(idle), 32'd1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
